// File: rtl/opcode_decoder_if.sv
// Fetch-to-execute handshake bundle for the opcode decoder stage.
// The master drives words in and accepts decoded entries out. The slave is the decoder.
interface opcode_decoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic        out_valid;
  logic        out_ready;
  logic [5:0]  out_class;
  logic        out_illegal;
  logic [4:0]  out_rd;
  logic [4:0]  out_rs1;
  logic [2:0]  out_funct3;

  modport master (
    output in_valid, in_instr, out_ready,
    input  in_ready, out_valid, out_class, out_illegal, out_rd, out_rs1, out_funct3
  );

  modport slave (
    input  in_valid, in_instr, out_ready,
    output in_ready, out_valid, out_class, out_illegal, out_rd, out_rs1, out_funct3
  );
endinterface

// File: rtl/opcode_decoder.sv
// opcode_decoder: maps a raw RV32 instruction word back to its 6-bit opcode class index
// and extracts rd/rs1/funct3. It is a single registered stage with a valid/ready handshake.
// It has an optional 2-entry skid buffer, a flush input, and saturating legal/illegal counters.
module opcode_decoder #(
  parameter int CNT_W   = 16,
  parameter bit SKID_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  opcode_decoder_if.slave  bus,
  output logic [CNT_W-1:0] decoded_cnt,
  output logic [CNT_W-1:0] illegal_cnt
);

  typedef struct packed {
    logic [5:0] cls;
    logic       illegal;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [2:0] funct3;
  } entry_t;

  entry_t           w_dec;
  entry_t           r_main, r_skid, w_main_nx, w_skid_nx;
  logic             r_main_vld, r_skid_vld, w_main_vld_nx, w_skid_vld_nx;
  logic [CNT_W-1:0] r_dcnt, r_icnt, w_dcnt_nx, w_icnt_nx;
  logic             w_in_rdy, w_push, w_pop;

  // Combinational decode of the incoming word. Unsupported major opcodes fall back to 6'h3F.
  always_comb begin
    w_dec         = '0;
    w_dec.rd      = bus.in_instr[11:7];
    w_dec.rs1     = bus.in_instr[19:15];
    w_dec.funct3  = bus.in_instr[14:12];
    w_dec.cls     = 6'h3F;
    w_dec.illegal = 1'b1;
    if (bus.in_instr[1:0] == 2'b11) begin
      case (bus.in_instr[6:2])
        5'b00000, 5'b00001, 5'b00010, 5'b00011, 5'b00100, 5'b00101,
        5'b01000, 5'b01100, 5'b01101, 5'b11000, 5'b11001, 5'b11011,
        5'b11100: begin
          w_dec.cls     = {1'b0, bus.in_instr[6:2]};
          w_dec.illegal = 1'b0;
        end
        default: ;
      endcase
    end
  end

  // With the skid buffer, ready comes straight from a flop. Without it, ready looks through
  // to out_ready so that a pop and a push can happen in the same cycle.
  assign w_in_rdy = SKID_EN ? ~r_skid_vld : (~r_main_vld | bus.out_ready);
  assign w_push   = bus.in_valid & w_in_rdy;
  assign w_pop    = r_main_vld & bus.out_ready;

  // Next-state logic for storage and counters. Flush overrides push and pop.
  // The skid entry always refills main before a new word can.
  always_comb begin
    w_main_nx     = r_main;
    w_skid_nx     = r_skid;
    w_main_vld_nx = r_main_vld;
    w_skid_vld_nx = r_skid_vld;
    w_dcnt_nx     = r_dcnt;
    w_icnt_nx     = r_icnt;
    if (flush) begin
      w_main_vld_nx = 1'b0;
      w_skid_vld_nx = 1'b0;
    end else begin
      if (w_pop) begin
        if (r_main.illegal) begin
          if (~&r_icnt) w_icnt_nx = r_icnt + CNT_W'(1);
        end else begin
          if (~&r_dcnt) w_dcnt_nx = r_dcnt + CNT_W'(1);
        end
      end
      if (!r_main_vld || w_pop) begin
        if (r_skid_vld) begin
          w_main_nx     = r_skid;
          w_main_vld_nx = 1'b1;
          w_skid_vld_nx = w_push;
          if (w_push) w_skid_nx = w_dec;
        end else begin
          w_main_vld_nx = w_push;
          if (w_push) w_main_nx = w_dec;
        end
      end else if (w_push) begin
        // Main is stalled, so the word parks in skid. This only happens when SKID_EN=1.
        w_skid_nx     = w_dec;
        w_skid_vld_nx = 1'b1;
      end
    end
  end

  // State registers. Reset clears all entries, the visible payload and both counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_main     <= '0;
      r_skid     <= '0;
      r_main_vld <= 1'b0;
      r_skid_vld <= 1'b0;
      r_dcnt     <= '0;
      r_icnt     <= '0;
    end else begin
      r_main     <= w_main_nx;
      r_skid     <= w_skid_nx;
      r_main_vld <= w_main_vld_nx;
      r_skid_vld <= w_skid_vld_nx;
      r_dcnt     <= w_dcnt_nx;
      r_icnt     <= w_icnt_nx;
    end
  end

  assign bus.in_ready    = w_in_rdy;
  assign bus.out_valid   = r_main_vld;
  assign bus.out_class   = r_main.cls;
  assign bus.out_illegal = r_main.illegal;
  assign bus.out_rd      = r_main.rd;
  assign bus.out_rs1     = r_main.rs1;
  assign bus.out_funct3  = r_main.funct3;
  assign decoded_cnt     = r_dcnt;
  assign illegal_cnt     = r_icnt;

endmodule

// File: tb/tb_opcode_decoder.sv
// Bench for opcode_decoder. Two instances receive the same stimulus:
//   A: SKID_EN=1, CNT_W=16
//   B: SKID_EN=0, CNT_W=2
// Each instance is compared every cycle against a queue model of the stage.
module tb_opcode_decoder;
  logic clk = 1'b0;
  logic rst, flush;
  logic [15:0] a_dc, a_ic;
  logic [1:0]  b_dc, b_ic;

  opcode_decoder_if if_a ();
  opcode_decoder_if if_b ();

  opcode_decoder #(.CNT_W(16), .SKID_EN(1'b1)) u_a (
    .clk(clk), .rst(rst), .flush(flush), .bus(if_a),
    .decoded_cnt(a_dc), .illegal_cnt(a_ic)
  );
  opcode_decoder #(.CNT_W(2), .SKID_EN(1'b0)) u_b (
    .clk(clk), .rst(rst), .flush(flush), .bus(if_b),
    .decoded_cnt(b_dc), .illegal_cnt(b_ic)
  );

  always #5 clk = ~clk;

  int n_err = 0;
  int n_chk = 0;

  // Model state, indexed 0=A, 1=B.
  logic [31:0] mq [2][4];
  int          mn [2];
  int          mdc [2];
  int          mic [2];
  int          cmax [2];
  bit          have_rst = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [5:0] ref_cls(input logic [31:0] w);
    logic [31:0] legal_mask;
    legal_mask = 32'h1B00_313F;
    if (w[1:0] == 2'b11 && legal_mask[w[6:2]]) return {1'b0, w[6:2]};
    return 6'h3F;
  endfunction

  function automatic bit ref_rdy(input int d, input bit ordy);
    if (d == 0) return mn[0] < 2;
    return (mn[1] == 0) || ordy;
  endfunction

  // One clock cycle, starting and ending just after a falling edge:
  //   1. drive the inputs,
  //   2. compare both DUTs with the model,
  //   3. advance the model,
  //   4. cross the rising edge.
  task automatic step(input bit v, input logic [31:0] ins, input bit ordy, input bit fl, input bit rs);
    logic       o_rdy [2], o_vld [2], o_ill [2];
    logic [5:0] o_cls [2];
    logic [4:0] o_rd [2], o_rs1 [2];
    logic [2:0] o_f3 [2];
    int         o_dc [2], o_ic [2];
    bit         rdy, pop, push;
    rst = rs; flush = fl;
    if_a.in_valid = v; if_a.in_instr = ins; if_a.out_ready = ordy;
    if_b.in_valid = v; if_b.in_instr = ins; if_b.out_ready = ordy;
    #1;
    o_rdy[0] = if_a.in_ready; o_vld[0] = if_a.out_valid; o_ill[0] = if_a.out_illegal;
    o_cls[0] = if_a.out_class; o_rd[0] = if_a.out_rd; o_rs1[0] = if_a.out_rs1;
    o_f3[0] = if_a.out_funct3; o_dc[0] = int'(a_dc); o_ic[0] = int'(a_ic);
    o_rdy[1] = if_b.in_ready; o_vld[1] = if_b.out_valid; o_ill[1] = if_b.out_illegal;
    o_cls[1] = if_b.out_class; o_rd[1] = if_b.out_rd; o_rs1[1] = if_b.out_rs1;
    o_f3[1] = if_b.out_funct3; o_dc[1] = int'(b_dc); o_ic[1] = int'(b_ic);
    for (int d = 0; d < 2; d++) begin
      if (have_rst) begin
        chk(d ? "b_in_ready" : "a_in_ready", 32'(o_rdy[d]), 32'(ref_rdy(d, ordy)));
        chk(d ? "b_out_valid" : "a_out_valid", 32'(o_vld[d]), 32'(mn[d] > 0));
        chk(d ? "b_decoded_cnt" : "a_decoded_cnt", o_dc[d], mdc[d]);
        chk(d ? "b_illegal_cnt" : "a_illegal_cnt", o_ic[d], mic[d]);
        if (mn[d] > 0) begin
          chk(d ? "b_class" : "a_class", 32'(o_cls[d]), 32'(ref_cls(mq[d][0])));
          chk(d ? "b_illegal" : "a_illegal", 32'(o_ill[d]), 32'(ref_cls(mq[d][0]) == 6'h3F));
          chk(d ? "b_rd" : "a_rd", 32'(o_rd[d]), 32'(mq[d][0][11:7]));
          chk(d ? "b_rs1" : "a_rs1", 32'(o_rs1[d]), 32'(mq[d][0][19:15]));
          chk(d ? "b_funct3" : "a_funct3", 32'(o_f3[d]), 32'(mq[d][0][14:12]));
        end
      end
      rdy = ref_rdy(d, ordy);
      if (rs) begin
        mn[d] = 0; mdc[d] = 0; mic[d] = 0;
      end else if (fl) begin
        mn[d] = 0;
      end else begin
        pop  = (mn[d] > 0) && ordy;
        push = v && rdy;
        if (pop) begin
          if (ref_cls(mq[d][0]) == 6'h3F) mic[d] = (mic[d] < cmax[d]) ? mic[d] + 1 : cmax[d];
          else                            mdc[d] = (mdc[d] < cmax[d]) ? mdc[d] + 1 : cmax[d];
          for (int k = 0; k < 3; k++) mq[d][k] = mq[d][k+1];
          mn[d]--;
        end
        if (push) begin
          mq[d][mn[d]] = ins;
          mn[d]++;
        end
      end
    end
    if (rs) have_rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic reset_chk();
    chk("rst_a_valid", 32'(if_a.out_valid), 0);
    chk("rst_a_ready", 32'(if_a.in_ready), 1);
    chk("rst_a_class", 32'(if_a.out_class), 0);
    chk("rst_a_illegal", 32'(if_a.out_illegal), 0);
    chk("rst_a_rd", 32'(if_a.out_rd), 0);
    chk("rst_a_rs1", 32'(if_a.out_rs1), 0);
    chk("rst_a_funct3", 32'(if_a.out_funct3), 0);
    chk("rst_a_cnts", 32'({a_dc, a_ic}), 0);
    chk("rst_b_valid", 32'(if_b.out_valid), 0);
    chk("rst_b_ready", 32'(if_b.in_ready), 1);
    chk("rst_b_class", 32'(if_b.out_class), 0);
    chk("rst_b_cnts", 32'({b_dc, b_ic}), 0);
  endtask

  initial begin
    logic [4:0] ops [13];
    logic [31:0] w;
    ops = '{5'b00000, 5'b00001, 5'b00010, 5'b00011, 5'b00100, 5'b00101, 5'b01000,
            5'b01100, 5'b01101, 5'b11000, 5'b11001, 5'b11011, 5'b11100};
    cmax[0] = 65535; cmax[1] = 3;
    mn[0] = 0; mn[1] = 0;
    mdc[0] = 0; mdc[1] = 0; mic[0] = 0; mic[1] = 0;

    step(0, 0, 1, 0, 1);
    step(0, 0, 1, 0, 1);
    reset_chk();

    // lw x1,0(x0)
    step(1, 32'h0000_2083, 1, 0, 0);
    chk("lw_valid", 32'(if_a.out_valid), 1);
    chk("lw_class", 32'(if_a.out_class), 0);
    chk("lw_rd", 32'(if_a.out_rd), 1);
    chk("lw_funct3", 32'(if_a.out_funct3), 2);
    chk("lw_cnt_before", 32'(a_dc), 0);

    // back-to-back addi, fence, nop
    step(1, 32'h0050_0093, 1, 0, 0);
    chk("addi_class", 32'(if_a.out_class), 4);
    chk("lw_cnt_after", 32'(a_dc), 1);
    step(1, 32'h0000_000F, 1, 0, 0);
    chk("fence_class", 32'(if_a.out_class), 3);
    step(1, 32'h0000_0013, 1, 0, 0);
    chk("nop_class", 32'(if_a.out_class), 4);

    // illegal words
    step(1, 32'h0000_0000, 1, 0, 0);
    chk("ill0_class", 32'(if_a.out_class), 32'h3F);
    chk("ill0_flag", 32'(if_a.out_illegal), 1);
    step(1, 32'h0000_007F, 1, 0, 0);
    chk("ill7f_class", 32'(if_a.out_class), 32'h3F);
    step(0, 0, 1, 0, 0);
    chk("ill_cnt", 32'(a_ic), 2);
    chk("dec_cnt_kept", 32'(a_dc), 4);

    // skid: stall the output, then push three words
    step(1, 32'h0010_0093, 0, 0, 0);
    step(1, 32'h0000_10B7, 0, 0, 0);
    chk("skid_full_rdy", 32'(if_a.in_ready), 0);
    step(1, 32'h0000_0063, 0, 0, 0);
    step(1, 32'h0000_0063, 1, 0, 0);
    chk("skid_to_main", 32'(if_a.out_class), 32'h0D);
    chk("skid_freed_rdy", 32'(if_a.in_ready), 1);
    step(1, 32'h0000_0063, 1, 0, 0);
    chk("third_class", 32'(if_a.out_class), 32'h18);
    step(0, 0, 1, 0, 0);
    step(0, 0, 1, 0, 0);
    chk("b_saturated", 32'(b_dc), 3);

    // flush with two entries buffered and a word presented
    step(1, 32'h0020_0113, 0, 0, 0);
    step(1, 32'h0030_0193, 0, 0, 0);
    step(1, 32'h0040_0213, 0, 1, 0);
    chk("flush_valid", 32'(if_a.out_valid), 0);
    chk("flush_ready", 32'(if_a.in_ready), 1);
    step(0, 0, 1, 0, 0);
    step(0, 0, 1, 0, 0);

    // reset while holding a valid entry
    step(1, 32'h0000_2083, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    reset_chk();

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      w = $urandom;
      if ($urandom_range(0, 3) != 0) w[6:0] = {ops[$urandom_range(0, 12)], 2'b11};
      step($urandom_range(0, 3) != 0, w, $urandom_range(0, 2) != 0,
           $urandom_range(0, 49) == 0, $urandom_range(0, 299) == 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/opcode_decoder.md
Name: opcode_decoder

Overview:
- Inverse of the core's class-index-to-major-opcode mapping: takes raw 32-bit RV32 instruction words from fetch and recovers the 6-bit opcode class index plus the basic register fields.
- Registered, valid/ready-handshaked pipeline stage between fetch and execute.
- Contains a 2-entry skid buffer, a flush, and saturating statistics counters.

Parameters:
- CNT_W, 16, width of the decoded and illegal statistics counters.
- SKID_EN, 1, 1 = 2-entry skid buffer (full throughput with registered in_ready); 0 = single register (in_ready = ~full | out_ready).

Ports:
- clk  input  1  core clock, all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- flush  input  1  drop all buffered entries this cycle.
- in_valid  input  1  instruction word valid.
- in_ready  output  1  stage can accept a word.
- in_instr  input  32  raw instruction word.
- out_valid  output  1  decoded entry available.
- out_ready  input  1  downstream accepts the entry.
- out_class  output  6  opcode class index; 6'h3F = illegal.
- out_illegal  output  1  entry is illegal.
- out_rd  output  5  instr[11:7].
- out_rs1  output  5  instr[19:15].
- out_funct3  output  3  instr[14:12].
- decoded_cnt  output  CNT_W  count of legal entries consumed at output.
- illegal_cnt  output  CNT_W  count of illegal entries consumed at output.

Behaviour:
- Class index (the same index space as the core's index-to-opcode mapping): out_class = {1'b0, instr[6:2]} when instr[1:0]==2'b11 and instr[6:2] is in the supported set.
- Supported instr[6:2] set: 00000 LOAD, 00001 LOAD_FP, 00010 CUSTOM_0, 00011 MISC_MEM, 00100 OP_IMM, 00101 AUIPC, 01000 STORE, 01100 OP, 01101 LUI, 11000 BRANCH, 11001 JALR, 11011 JAL, 11100 SYSTEM.
- Illegal entries:
  - Any other instr[6:2] value, or instr[1:0]!=2'b11, gives out_class=6'h3F and out_illegal=1.
  - out_rd, out_rs1 and out_funct3 are still passed through unmodified.
- Decode is combinational on in_instr; the result is registered.
- Latency: exactly 1 cycle. A word accepted on edge N (in_valid & in_ready) has out_valid=1 after edge N.
- Handshake:
  - Transfer occurs when valid & ready are both high at a rising edge.
  - out_valid and out_* hold stable while out_valid & ~out_ready.
  - in_ready does not depend combinationally on in_valid.
- SKID_EN=1:
  - Storage: main register plus skid register.
  - in_ready = ~skid_full, registered.
  - If the main register is full, out_ready=0 and a word arrives, the word goes to skid.
  - When main drains, skid moves to main in the same edge.
  - Throughput: 1 word/cycle in steady state with out_ready=1.
  - Order is strictly FIFO.
- SKID_EN=0: in_ready = ~main_full | out_ready. Simultaneous pop and push replaces the entry in place.
- Flush:
  - Clears main and skid valid on the edge.
  - A word presented with flush high is dropped and not counted.
  - in_ready=1 in the next cycle.
  - Counters are not changed by flush.
- Counters:
  - On each output transfer, increment decoded_cnt if out_illegal=0, else illegal_cnt.
  - Both saturate at all-ones, with no wrap.
- Reset (rst=1 at edge):
  - out_valid=0, in_ready=1.
  - out_class=0, out_illegal=0, out_rd=0, out_rs1=0, out_funct3=0.
  - Both counters 0, skid empty.
  - Reset mid-transfer discards all entries.
  - rst has priority over flush; flush has priority over push and pop.

Test Plan:
- Reset, then in_instr=32'h00002083 (lw x1,0(x0)), out_ready=1 -> next cycle out_valid=1, out_class=0, out_rd=1, out_funct3=2, decoded_cnt=1 after the transfer.
- Back-to-back words 32'h00500093 (addi), 32'h0000000F (fence), 32'h00000013 with out_ready=1 -> classes 4, 3, 4 on consecutive cycles; in_ready stays 1.
- 32'h00000000 and 32'h0000007F -> out_class=6'h3F, out_illegal=1; illegal_cnt=2, decoded_cnt unchanged.
- SKID_EN=1: hold out_ready=0 and push 3 words -> the first two are accepted and in_ready=0 on the third; release out_ready -> outputs in order; the third is accepted in the cycle after the skid frees.
- Two entries buffered, flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1, counters unchanged, the flushed word never appears.
- CNT_W=2: consume 5 legal entries -> decoded_cnt=3 (saturated). rst asserted while out_valid=1 -> all outputs 0, in_ready=1.
